chunk_serial_adder: RTL and testbench
=====================================

Name: chunk_serial_adder

Overview:
- Parametrised multi-cycle N-bit adder; successor to the one-bit half/full adder labs.
- Adds WIDTH-bit operands CHUNK bits per clock, with the carry held in a register between chunks.
- Uses a start/ready/done handshake.
- Used where a full-width single-cycle carry chain is too slow or too large; sits between a register-file/datapath source and a result consumer.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle; 1 <= CHUNK <= WIDTH.
- NUM_CHUNKS (localparam, derived), WIDTH/CHUNK, number of processing cycles.

Ports:
- clock  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start_in  input  1  request; accepted only while ready_out=1.
- a_in  input  WIDTH  operand A, sampled at acceptance.
- b_in  input  WIDTH  operand B, sampled at acceptance.
- carry_in  input  1  carry into bit 0, sampled at acceptance.
- ready_out  output  1  block idle, can accept start_in.
- sum_out  output  WIDTH  registered result, held until the next result is written.
- carry_out  output  1  registered carry out of MSB, held like sum_out.
- done_out  output  1  one-cycle pulse: sum_out/carry_out were just updated.

Behaviour:
- Reset (async assert, sync-free deassert): state=IDLE, chunk index=0, operand/carry registers=0, sum_out=0, carry_out=0, done_out=0, ready_out=1.
- FSM states: IDLE, RUN, DONE.
- IDLE: ready_out=1. On a rising edge with start_in=1:
  - capture a_in, b_in, carry_in;
  - clear the working sum register and set index=0;
  - go to RUN.
- RUN: ready_out=0. Each edge:
  - compute {c, s} = A[idx*CHUNK +: CHUNK] + B[idx*CHUNK +: CHUNK] + carry_reg, in CHUNK+1 bits;
  - write s into the working sum slice idx; carry_reg <= c; idx <= idx+1.
  - On the edge processing idx==NUM_CHUNKS-1: load sum_out with the full working sum (including the final slice) and carry_out with the final c, then go to DONE.
- DONE: done_out=1 for exactly this cycle; ready_out=0. Next edge: go to IDLE unconditionally.
- Latency: start accepted at edge T -> done_out high during the cycle after edge T+NUM_CHUNKS. Throughput: one operation per NUM_CHUNKS+2 cycles.
- start_in while ready_out=0 is ignored; no queuing, and the in-flight operands are unaffected.
- start_in held high continuously: a new operation is accepted on the first edge in IDLE after each DONE.
- Input changes after acceptance have no effect on the result.
- sum_out/carry_out change only on the RUN->DONE edge or on reset; they stay stable throughout IDLE and RUN.
- NUM_CHUNKS==1 (CHUNK==WIDTH): one RUN cycle; latency 2 edges to DONE.
- Reset asserted mid-RUN or in DONE: the operation is abandoned, no done_out pulse, and all registers take their reset values immediately.
- Wrap-around: the sum is modulo 2^WIDTH; overflow is visible only via carry_out.

Optional Feature:
- Macro: CHUNK_ADDER_SUB_EN.
- Defined:
  - adds input port sub_in (1 bit), sampled with the operands at acceptance;
  - sub_in=1 captures ~b_in and forces the initial carry to 1, ignoring carry_in, giving A-B two's complement;
  - carry_out=1 means no borrow (A>=B unsigned);
  - sub_in=0 behaves exactly as the base block.
- Undefined: sub_in port is absent; add-only behaviour as above.

Decomposition:
- Shared package chunk_adder_pkg:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default WIDTH/CHUNK constants;
  - a clog2-style helper for the index width.
- One natural sub-module: chunk_full_adder, a combinational CHUNK-bit adder with carry in/out, instantiated once and reused every RUN cycle.

Test Plan:
- WIDTH=16, CHUNK=4: a=0x1234, b=0x4321, cin=0, start pulse -> done_out exactly 5 edges later; sum_out=0x5555, carry_out=0; ready_out low for 5 cycles.
- a=0xFFFF, b=0x0001, cin=0 -> sum_out=0x0000, carry_out=1, confirming carry propagation through all 4 chunks. Also a=0xFFFF, b=0x0000, cin=1 -> same result.
- Start accepted with a=0x0F0F; pulse start_in with a=0x1111 during RUN -> ignored; result reflects 0x0F0F operands; only one done_out pulse.
- Assert reset_n=0 on the 2nd RUN cycle -> immediately ready_out=1, sum_out=0, carry_out=0, no done_out. After release, 0x0001+0x0001 -> 0x0002.
- start_in held at 1 with changing operands -> back-to-back results every 6 cycles; sum_out stable between done pulses.
- With CHUNK_ADDER_SUB_EN: a=0x0005, b=0x0007, sub_in=1 -> sum_out=0xFFFE, carry_out=0. Then a=0x0007, b=0x0005, sub_in=1 -> sum_out=0x0002, carry_out=1.

Source files
------------

// File: rtl/chunk_adder_pkg.sv
// Shared definitions for the chunk-serial adder.
//   state_t        FSM state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  default operand/sum width
//   DEFAULT_CHUNK  default bits added per clock
//   index_width()  bits needed to hold an index in 0..count-1 (never below 1)
package chunk_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_CHUNK = 4;

   // A single-entry index still needs one bit so the register is never zero-width.
   function automatic int index_width(input int count);
      int w;
      w = 1;
      while ((1 << w) < count) w++;
      return w;
   endfunction

endpackage

// File: rtl/chunk_full_adder.sv
// Combinational CHUNK-bit adder with carry in and carry out.
// Ports:
//   a, b   CHUNK-bit addends
//   cin    carry into bit 0
//   sum    CHUNK-bit sum
//   cout   carry out of the top bit
module chunk_full_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/chunk_serial_adder.sv
// Multi-cycle WIDTH-bit adder that adds CHUNK bits per clock, holding the
// inter-chunk carry in a register. One operation takes WIDTH/CHUNK RUN cycles
// followed by a one-cycle DONE pulse.
// Optional feature macro: CHUNK_ADDER_SUB_EN adds sub_in for A-B.
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   start_in   request, accepted only while ready_out=1
//   a_in/b_in  operands, sampled at acceptance
//   carry_in   carry into bit 0, sampled at acceptance
//   sub_in     (CHUNK_ADDER_SUB_EN only) 1 = compute a_in - b_in
//   ready_out  idle and able to accept start_in
//   sum_out    registered sum, held until the next result
//   carry_out  registered carry out of the MSB (no-borrow flag when subtracting)
//   done_out   one-cycle pulse after sum_out/carry_out were updated
module chunk_serial_adder
   import chunk_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CHUNK = DEFAULT_CHUNK
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             carry_in,
`ifdef CHUNK_ADDER_SUB_EN
   input  logic             sub_in,
`endif
   output logic             ready_out,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out,
   output logic             done_out
);

   localparam int NUM_CHUNKS = WIDTH / CHUNK;
   localparam int IDX_W      = index_width(NUM_CHUNKS);
   localparam int BASE_W     = index_width(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   state_t             state, state_next;
   logic [WIDTH-1:0]   a_reg, b_reg, work_sum, work_next;
   logic               carry_reg;
   logic [IDX_W-1:0]   idx;
   logic [BASE_W-1:0]  base;
   logic [CHUNK-1:0]   a_slice, b_slice, s_slice;
   logic               c_slice;
   logic [WIDTH-1:0]   b_op;
   logic               cin_op;

   // Subtraction is A + ~B + 1, so it only changes what gets captured.
`ifdef CHUNK_ADDER_SUB_EN
   assign b_op   = sub_in ? ~b_in : b_in;
   assign cin_op = sub_in ? 1'b1  : carry_in;
`else
   assign b_op   = b_in;
   assign cin_op = carry_in;
`endif

   always_comb begin
      base    = BASE_W'(int'(idx) * CHUNK);
      a_slice = a_reg[base +: CHUNK];
      b_slice = b_reg[base +: CHUNK];
   end

   chunk_full_adder #(.CHUNK(CHUNK)) u_adder (
      .a    (a_slice),
      .b    (b_slice),
      .cin  (carry_reg),
      .sum  (s_slice),
      .cout (c_slice)
   );

   // Working sum with the current slice merged in; on the last chunk this is
   // the complete result loaded into sum_out.
   always_comb begin
      work_next = work_sum;
      work_next[base +: CHUNK] = s_slice;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      ready_out  = 1'b0;
      done_out   = 1'b0;
      case (state)
         IDLE: begin
            ready_out = 1'b1;
            if (start_in) state_next = RUN;
         end
         RUN: begin
            if (idx == LAST_IDX) state_next = DONE;
         end
         DONE: begin
            done_out   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         work_sum  <= '0;
         idx       <= '0;
         sum_out   <= '0;
         carry_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_in) begin
                  a_reg     <= a_in;
                  b_reg     <= b_op;
                  carry_reg <= cin_op;
                  work_sum  <= '0;
                  idx       <= '0;
               end
            end
            RUN: begin
               work_sum  <= work_next;
               carry_reg <= c_slice;
               idx       <= idx + IDX_W'(1);
               if (idx == LAST_IDX) begin
                  sum_out   <= work_next;
                  carry_out <= c_slice;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chunk_serial_adder.sv
module tb_chunk_serial_adder;

   typedef struct packed {
      logic [15:0] s;
      logic        c;
   } exp_t;

   logic        clock;
   logic        reset_n;
   logic        start_in;
   logic [15:0] a_in, b_in;
   logic        carry_in;
`ifdef CHUNK_ADDER_SUB_EN
   logic        sub_in;
`endif
   logic        ready_out;
   logic [15:0] sum_out;
   logic        carry_out;
   logic        done_out;

   int   errors;
   int   checks;
   exp_t sb[$];
   logic [15:0] last_exp_sum;

   chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start_in  (start_in),
      .a_in      (a_in),
      .b_in      (b_in),
      .carry_in  (carry_in),
`ifdef CHUNK_ADDER_SUB_EN
      .sub_in    (sub_in),
`endif
      .ready_out (ready_out),
      .sum_out   (sum_out),
      .carry_out (carry_out),
      .done_out  (done_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic sub);
      logic [16:0] r;
      exp_t e;
      if (sub) r = {1'b0, a} + {1'b0, ~b} + 17'd1;
      else     r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      e.s = r[15:0];
      e.c = r[16];
      return e;
   endfunction

   // Drives one start pulse at a negedge; returns at the negedge after the accepting edge.
   task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input logic sub, input bit push);
      @(negedge clock);
      a_in = a; b_in = b; carry_in = cin; start_in = 1'b1;
`ifdef CHUNK_ADDER_SUB_EN
      sub_in = sub;
`endif
      if (push) sb.push_back(model(a, b, cin, sub));
      @(negedge clock);
      start_in = 1'b0;
      a_in = $urandom(); b_in = $urandom(); carry_in = 1'b0;
`ifdef CHUNK_ADDER_SUB_EN
      sub_in = 1'b0;
`endif
   endtask

   // Bounded wait at negedges until done_out is seen; edges = posedges passed.
   task automatic wait_done(output int edges);
      edges = 0;
      while (done_out !== 1'b1 && edges < 40) begin
         @(negedge clock);
         edges++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start_in = 1'b0; a_in = '0; b_in = '0; carry_in = 1'b0;
`ifdef CHUNK_ADDER_SUB_EN
      sub_in = 1'b0;
`endif
      repeat (2) @(negedge clock);
      checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready_out); end
      checks++; if (sum_out !== 16'h0) begin errors++; $display("FAIL reset_sum got=%h want=0000", sum_out); end
      checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b want=0", carry_out); end
      checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done_out); end
      reset_n = 1'b1;
      last_exp_sum = 16'h0;
   endtask

   task automatic test_basic();
      exp_t e;
      start_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
      // k = cycles after the accepting edge: RUN x4, DONE, then IDLE.
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clock);
         checks++;
         if (ready_out !== (k == 5)) begin
            errors++; $display("FAIL basic_ready k=%0d got=%b want=%b", k, ready_out, (k == 5));
         end
         checks++;
         if (done_out !== (k == 4)) begin
            errors++; $display("FAIL basic_done k=%0d got=%b want=%b", k, done_out, (k == 4));
         end
         if (k == 4) begin
            if (sb.size() == 0) begin
               checks++; errors++; $display("FAIL basic_sb got=empty want=entry");
            end else begin
               e = sb.pop_front();
               last_exp_sum = e.s;
               checks++;
               if (sum_out !== e.s || e.s !== 16'h5555) begin
                  errors++; $display("FAIL basic_sum got=%h want=%h", sum_out, e.s);
               end
               checks++;
               if (carry_out !== e.c) begin
                  errors++; $display("FAIL basic_cout got=%b want=%b", carry_out, e.c);
               end
            end
         end
      end
   endtask

   task automatic test_carry();
      exp_t e;
      int edges;
      logic [15:0] bs [2] = '{16'h0001, 16'h0000};
      logic        cs [2] = '{1'b0, 1'b1};
      for (int i = 0; i < 2; i++) begin
         start_op(16'hFFFF, bs[i], cs[i], 1'b0, 1'b1);
         wait_done(edges);
         checks++;
         if (edges != 4) begin errors++; $display("FAIL carry_latency%0d got=%0d want=4", i, edges); end
         e = sb.pop_front();
         last_exp_sum = e.s;
         checks++;
         if (sum_out !== e.s) begin errors++; $display("FAIL carry_sum%0d got=%h want=%h", i, sum_out, e.s); end
         checks++;
         if (carry_out !== 1'b1) begin errors++; $display("FAIL carry_cout%0d got=%b want=1", i, carry_out); end
      end
   endtask

   task automatic test_ignore();
      exp_t e;
      int edges;
      int dones;
      start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b1);
      // RUN cycle 1: request a different operation that must be dropped.
      a_in = 16'h1111; b_in = 16'h2222; carry_in = 1'b1; start_in = 1'b1;
      @(negedge clock);
      start_in = 1'b0;
      wait_done(edges);
      e = sb.pop_front();
      last_exp_sum = e.s;
      checks++;
      if (sum_out !== e.s) begin errors++; $display("FAIL ignore_sum got=%h want=%h", sum_out, e.s); end
      checks++;
      if (carry_out !== e.c) begin errors++; $display("FAIL ignore_cout got=%b want=%b", carry_out, e.c); end
      dones = 0;
      repeat (10) begin
         @(negedge clock);
         if (done_out === 1'b1) dones++;
      end
      checks++;
      if (dones != 0) begin errors++; $display("FAIL ignore_extra_done got=%0d want=0", dones); end
      checks++;
      if (ready_out !== 1'b1) begin errors++; $display("FAIL ignore_idle got=%b want=1", ready_out); end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int edges;
      int dones;
      start_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b want=1", ready_out); end
      checks++; if (sum_out !== 16'h0) begin errors++; $display("FAIL midrst_sum got=%h want=0000", sum_out); end
      checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL midrst_cout got=%b want=0", carry_out); end
      last_exp_sum = 16'h0;
      dones = 0;
      repeat (3) begin
         @(negedge clock);
         if (done_out === 1'b1) dones++;
      end
      reset_n = 1'b1;
      repeat (6) begin
         @(negedge clock);
         if (done_out === 1'b1) dones++;
      end
      checks++;
      if (dones != 0) begin errors++; $display("FAIL midrst_done got=%0d want=0", dones); end
      start_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
      wait_done(edges);
      e = sb.pop_front();
      last_exp_sum = e.s;
      checks++;
      if (sum_out !== 16'h0002 || e.s !== 16'h0002) begin
         errors++; $display("FAIL midrst_after got=%h want=0002", sum_out);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [15:0] as [3] = '{16'h1000, 16'hABCD, 16'h8000};
      logic [15:0] bs [3] = '{16'h0234, 16'h1111, 16'h8001};
      int pushed, popped, cyc, last_done;
      int unstable;
      pushed = 0; popped = 0; cyc = 0; last_done = -1; unstable = 0;
      @(negedge clock);
      while (popped < 3 && cyc < 60) begin
         if (pushed == 3) start_in = 1'b0;
         if (done_out === 1'b1) begin
            if (sb.size() == 0) begin
               checks++; errors++; $display("FAIL b2b_sb got=empty want=entry");
            end else begin
               e = sb.pop_front();
               last_exp_sum = e.s;
               checks++;
               if (sum_out !== e.s || carry_out !== e.c) begin
                  errors++; $display("FAIL b2b_result%0d got=%h/%b want=%h/%b", popped, sum_out, carry_out, e.s, e.c);
               end
            end
            if (last_done >= 0) begin
               checks++;
               if (cyc - last_done != 6) begin
                  errors++; $display("FAIL b2b_interval got=%0d want=6", cyc - last_done);
               end
            end
            last_done = cyc;
            popped++;
         end else if (sum_out !== last_exp_sum) begin
            unstable++;
         end
         if (ready_out === 1'b1 && pushed < 3) begin
            a_in = as[pushed]; b_in = bs[pushed]; carry_in = pushed[0]; start_in = 1'b1;
            sb.push_back(model(as[pushed], bs[pushed], pushed[0], 1'b0));
            pushed++;
         end
         @(negedge clock);
         cyc++;
      end
      start_in = 1'b0;
      checks++;
      if (popped != 3) begin errors++; $display("FAIL b2b_count got=%0d want=3", popped); end
      checks++;
      if (unstable != 0) begin errors++; $display("FAIL b2b_stable got=%0d want=0", unstable); end
      repeat (3) @(negedge clock);
   endtask

`ifdef CHUNK_ADDER_SUB_EN
   task automatic test_sub();
      exp_t e;
      int edges;
      start_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
      wait_done(edges);
      e = sb.pop_front();
      last_exp_sum = e.s;
      checks++;
      if (sum_out !== 16'hFFFE || carry_out !== 1'b0) begin
         errors++; $display("FAIL sub_neg got=%h/%b want=fffe/0", sum_out, carry_out);
      end
      start_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1);
      wait_done(edges);
      e = sb.pop_front();
      last_exp_sum = e.s;
      checks++;
      if (sum_out !== 16'h0002 || carry_out !== 1'b1) begin
         errors++; $display("FAIL sub_pos got=%h/%b want=0002/1", sum_out, carry_out);
      end
      // sub_in=0 with carry_in=1 stays a plain add.
      start_op(16'h0007, 16'h0005, 1'b1, 1'b0, 1'b1);
      wait_done(edges);
      e = sb.pop_front();
      last_exp_sum = e.s;
      checks++;
      if (sum_out !== e.s || carry_out !== e.c) begin
         errors++; $display("FAIL sub_off got=%h/%b want=%h/%b", sum_out, carry_out, e.s, e.c);
      end
   endtask
`endif

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_basic();
      test_carry();
      test_ignore();
      test_reset_mid();
      test_back_to_back();
`ifdef CHUNK_ADDER_SUB_EN
      test_sub();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
